// File: rtl/clock_timekeeper_if.sv
// Set-time handshake bundle: the requester drives set_valid and the requested time,
// and the timekeeper answers with set_ready and set_error.
interface clock_timekeeper_if;
  logic       set_valid;
  logic [7:0] set_hour;
  logic [7:0] set_min;
  logic [7:0] set_sec;
  logic       set_ready;
  logic       set_error;

  modport master (
    output set_valid, set_hour, set_min, set_sec,
    input  set_ready, set_error
  );

  modport slave (
    input  set_valid, set_hour, set_min, set_sec,
    output set_ready, set_error
  );
endinterface

// File: rtl/clock_timekeeper.sv
// Time-of-day counter: prescaler to 1 Hz tick, binary hh:mm:ss with carry pulses.
// Latency: a set request is visible on curr_* one edge after the edge that accepts it; set_ready is low during that LOAD cycle.
module clock_timekeeper #(
  parameter int TICKS_PER_SEC = 50000000,
  parameter int PRESC_W       = 26
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                run_en,
  clock_timekeeper_if.slave   setBus,
  output logic [7:0]          curr_hour,
  output logic [7:0]          curr_min,
  output logic [7:0]          curr_sec,
  output logic                sec_pulse,
  output logic                min_pulse,
  output logic                hour_pulse,
  output logic                day_pulse
);

  typedef enum logic {RUN, LOAD} state_t;

  state_t               stateQ, stateD;
  logic [PRESC_W-1:0]   presc;
  logic [7:0]           holdHour, holdMin, holdSec;
  logic                 inRun, accept, tick, advance, holdOk;

  assign inRun   = (stateQ == RUN);
  assign accept  = inRun && setBus.set_valid;
  assign tick    = inRun && run_en && (presc == PRESC_W'(TICKS_PER_SEC - 1));
  // A set accepted on a tick cycle swallows that tick; the loaded time wins.
  assign advance = tick && !accept;
  assign holdOk  = (holdHour <= 8'd23) && (holdMin <= 8'd59) && (holdSec <= 8'd59);

  // set_ready comes straight from the state register, so it stays registered.
  assign setBus.set_ready = inRun;

  always_comb begin
    stateD = stateQ;
    case (stateQ)
      RUN:     if (setBus.set_valid) stateD = LOAD;
      LOAD:    stateD = RUN;
      default: stateD = RUN;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) stateQ <= RUN;
    else       stateQ <= stateD;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc            <= '0;
      holdHour         <= 8'd0;
      holdMin          <= 8'd0;
      holdSec          <= 8'd0;
      curr_hour        <= 8'd0;
      curr_min         <= 8'd0;
      curr_sec         <= 8'd0;
      sec_pulse        <= 1'b0;
      min_pulse        <= 1'b0;
      hour_pulse       <= 1'b0;
      day_pulse        <= 1'b0;
      setBus.set_error <= 1'b0;
    end else begin
      sec_pulse        <= 1'b0;
      min_pulse        <= 1'b0;
      hour_pulse       <= 1'b0;
      day_pulse        <= 1'b0;
      setBus.set_error <= 1'b0;

      if (accept) begin
        holdHour <= setBus.set_hour;
        holdMin  <= setBus.set_min;
        holdSec  <= setBus.set_sec;
      end

      if (stateQ == LOAD) begin
        if (holdOk) begin
          curr_hour <= holdHour;
          curr_min  <= holdMin;
          curr_sec  <= holdSec;
          presc     <= '0;
        end else begin
          setBus.set_error <= 1'b1;
        end
      end else if (run_en) begin
        presc <= tick ? '0 : presc + PRESC_W'(1);
        if (advance) begin
          sec_pulse <= 1'b1;
          if (curr_sec == 8'd59) begin
            curr_sec  <= 8'd0;
            min_pulse <= 1'b1;
            if (curr_min == 8'd59) begin
              curr_min   <= 8'd0;
              hour_pulse <= 1'b1;
              if (curr_hour == 8'd23) begin
                curr_hour <= 8'd0;
                day_pulse <= 1'b1;
              end else begin
                curr_hour <= curr_hour + 8'd1;
              end
            end else begin
              curr_min <= curr_min + 8'd1;
            end
          end else begin
            curr_sec <= curr_sec + 8'd1;
          end
        end
      end
    end
  end

endmodule
